i2c_master_burst: RTL
=====================

Name: i2c_master_burst

Overview:
- Next-generation I2C master; replaces the single-byte master and its separate 400 kHz clock divider.
- Runs directly on the system clock, using an internal quarter-period tick whose rate is set by a parameter.
- Performs multi-byte write or read bursts of 0..MAX_LEN bytes to one 7-bit subordinate address.
- Streams bytes through valid/ready handshakes and drives open-drain SCL/SDA.

Parameters:
- QTR_DIV, 31, clk cycles per SCL quarter-period (50 MHz / (4*31) ≈ 403 kHz); minimum 2.
- MAX_LEN, 16, maximum bytes per transaction.
- LEN_W, $clog2(MAX_LEN+1), width of num_bytes.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- start_txn  input  1  request; sampled only while busy=0.
- rw  input  1  0=write, 1=read; latched at start.
- sub_addr  input  7  target address; latched at start.
- num_bytes  input  LEN_W  burst length; latched at start; values >MAX_LEN are clamped to MAX_LEN.
- tx_data  input  8  write byte.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  master accepts tx_data; transfer when tx_valid&tx_ready.
- rx_data  output  8  received byte; held until next rx_valid.
- rx_valid  output  1  one-cycle pulse per received byte.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse when the bus is released after STOP.
- ack_error  output  1  NACK seen; sticky until next accepted start_txn.
- SCL  inout  1  open-drain: drives 0 or Z.
- SDA  inout  1  open-drain: drives 0 or Z.

Behaviour:
- Reset: all outputs 0, rx_data=8'h00, SCL/SDA=Z, state IDLE, tick counter 0.
- Reset mid-transaction: the bus is released at the next edge; no STOP is generated.
- Tick: counter 0..QTR_DIV-1 runs only while busy. Each bit has 4 phases.
  - ph0: SCL low, SDA updated.
  - ph1: SCL released.
  - ph2: SCL high; SDA sampled on entry.
  - ph3: SCL pulled low.
- Accept: start_txn while busy=0 → busy=1 next cycle and ack_error cleared. start_txn while busy is ignored.
- FSM: IDLE → START → ADDR → ADDR_ACK → {WR_DATA ↔ WR_ACK | RD_DATA ↔ RD_ACK} → STOP → IDLE.
- START: SDA pulled low while SCL high for one quarter, then SCL low.
- ADDR: sends {sub_addr,rw}, MSB first. ADDR_ACK: releases SDA and samples at ph2.
- Address NACK: ack_error=1, then STOP.
- num_bytes=0: after ADDR_ACK, go to STOP (address probe).
- Write data:
  - tx_ready=1 at the end of each ACK phase while bytes remain.
  - If tx_valid is low, hold SCL low (stretch) and keep tx_ready high until the handshake completes.
  - The handshake lasts exactly one cycle; tx_ready falls the next cycle.
  - WR_DATA sends the byte MSB first; WR_ACK samples.
  - NACK: ack_error=1, then STOP; the remaining count is discarded.
- Read data:
  - RD_DATA releases SDA and shifts in on each ph2.
  - rx_data is updated and rx_valid pulses in the cycle after bit 0 is sampled.
  - RD_ACK drives ACK (0) if bytes remain, NACK (Z) on the last byte.
  - Read never sets ack_error.
- STOP: SDA low with SCL low, release SCL for one quarter, then release SDA for one quarter. Then done=1 for one cycle, busy=0 in the same cycle.
- Counters:
  - bit counter 3 bits, 7 down to 0.
  - byte counter LEN_W bits, decrements after each ACK phase; 0 means last byte done.
- No arbitration or multi-master detection; the SCL input is not monitored.

Decomposition:
- i2c_pkg: state enum typedef i2c_state_t, phase constants PH_LOW/PH_RISE/PH_HIGH/PH_FALL, ACK/NACK constants.
- Sub-module i2c_qtr_tick (QTR_DIV counter, enable, tick pulse, 2-bit phase output), instantiated once.

Test Plan:
- Write 3 bytes 8'hA5,8'h3C,8'hFF to addr 7'h01, with a single-byte subordinate model ACKing → bus shows START, 8'h02, ACK, three bytes each ACKed, STOP. Also: three tx handshakes, done pulse, ack_error=0.
- Read 2 bytes from addr 7'h03, subordinate returning 8'h5A,8'hC3 → address byte 8'h07; rx_valid pulses with 8'h5A then 8'hC3; master ACK after the first byte, NACK after the second; STOP; done.
- Write to unresponsive addr 7'h7F, num_bytes=4 → ack_error=1 after ADDR_ACK, no tx_ready, STOP, done; ack_error clears on the next start_txn.
- Write 2 bytes, tx_valid withheld 200 cycles before the second byte → SCL held low the whole time; the byte is sent correctly after tx_valid; no glitch on SDA while SCL is high.
- num_bytes=0 to addr 7'h01 → START, address, ACK, STOP, done; no tx_ready or rx_valid. Also: start_txn pulsed mid-transaction is ignored.
- Assert rst_n=0 during the 2nd data byte → next cycle SCL=SDA=Z, busy=0, done=0; a new transaction after reset completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the burst I2C master.
//   i2c_state_t : transaction FSM states
//   PH_*        : quarter-period phase encoding within one SCL bit
//   ACK / NACK  : SDA level of the acknowledge bit
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_STOP
  } i2c_state_t;

  localparam logic [1:0] PH_LOW  = 2'd0;
  localparam logic [1:0] PH_RISE = 2'd1;
  localparam logic [1:0] PH_HIGH = 2'd2;
  localparam logic [1:0] PH_FALL = 2'd3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-period timebase for the I2C master.
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : counter runs while high; low clears counter and phase
//   tick_c     : high in the last cycle of each quarter period
//   phase      : current quarter within the SCL bit (PH_LOW..PH_FALL)
module i2c_qtr_tick
  import i2c_pkg::*;
#(
  parameter int unsigned QTR_DIV = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       tick_c,
  output logic [1:0] phase
);

  localparam int unsigned CNT_W = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QTR_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt   <= '0;
      phase <= PH_LOW;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = en && (cnt == CNT_MAX);

endmodule

// File: rtl/i2c_master_burst.sv
// Burst I2C master: multi-byte write or read to one 7-bit address.
//   start_txn/rw/sub_addr/num_bytes : request, latched when accepted (busy=0)
//   tx_data/tx_valid/tx_ready       : write byte stream
//   rx_data/rx_valid                : read byte stream (rx_valid is a pulse)
//   busy/done/ack_error             : status (done pulses at bus release)
//   SCL/SDA                         : open-drain bus lines (drive 0 or Z)
module i2c_master_burst
  import i2c_pkg::*;
#(
  parameter int unsigned QTR_DIV = 31,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_txn,
  input  logic             rw,
  input  logic [6:0]       sub_addr,
  input  logic [LEN_W-1:0] num_bytes,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_error,
  inout  wire              SCL,
  inout  wire              SDA
);

  i2c_state_t       state;
  logic             rw_q;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic [7:0]       shreg;
  logic             scl_lo;
  logic             sda_lo;
  logic             ack_in;
  logic             tick_c;
  logic [1:0]       phase;
  logic [LEN_W-1:0] byte_left;
  logic [LEN_W-1:0] len_clamped;

  // Timebase freezes while waiting for a write byte, which stretches SCL low.
  i2c_qtr_tick #(.QTR_DIV(QTR_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (busy && !tx_ready),
    .tick_c (tick_c),
    .phase  (phase)
  );

  assign SCL = scl_lo ? 1'b0 : 1'bz;
  assign SDA = sda_lo ? 1'b0 : 1'bz;

  assign byte_left   = byte_cnt - LEN_W'(1);
  assign len_clamped = (32'(num_bytes) > MAX_LEN) ? LEN_W'(MAX_LEN) : num_bytes;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rw_q      <= 1'b0;
      bit_cnt   <= 3'd7;
      byte_cnt  <= '0;
      shreg     <= 8'h00;
      scl_lo    <= 1'b0;
      sda_lo    <= 1'b0;
      ack_in    <= ACK;
      tx_ready  <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      if (!busy) begin
        // Accept a new request
        if (start_txn) begin
          busy      <= 1'b1;
          state     <= ST_START;
          ack_error <= 1'b0;
          rw_q      <= rw;
          shreg     <= {sub_addr, rw};
          byte_cnt  <= len_clamped;
          bit_cnt   <= 3'd7;
        end
      end else if (tx_ready) begin
        // Stretch: SCL stays low until a write byte arrives, then drive its MSB
        if (tx_valid) begin
          tx_ready <= 1'b0;
          shreg    <= tx_data;
          sda_lo   <= ~tx_data[7];
          bit_cnt  <= 3'd7;
        end
      end else if (tick_c) begin
        case (phase)
          PH_LOW: scl_lo <= 1'b0;
          PH_RISE: begin
            // Entering SCL-high quarter: START/STOP edges and sampling
            case (state)
              ST_START: sda_lo <= 1'b1;
              ST_STOP:  sda_lo <= 1'b0;
              ST_ADDR_ACK, ST_WR_ACK: ack_in <= SDA;
              ST_RD_DATA: begin
                shreg <= {shreg[6:0], SDA};
                if (bit_cnt == 3'd0) begin
                  rx_data  <= {shreg[6:0], SDA};
                  rx_valid <= 1'b1;
                end
              end
              default: ;
            endcase
          end
          PH_HIGH: begin
            if (state == ST_STOP) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              scl_lo <= 1'b1;
            end
          end
          PH_FALL: begin
            // Bit boundary: choose next state and SDA level for the next bit
            case (state)
              ST_START: begin
                state   <= ST_ADDR;
                bit_cnt <= 3'd7;
                sda_lo  <= ~shreg[7];
              end
              ST_ADDR, ST_WR_DATA: begin
                if (bit_cnt == 3'd0) begin
                  state  <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
                  sda_lo <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  shreg   <= {shreg[6:0], 1'b0};
                  sda_lo  <= ~shreg[6];
                end
              end
              ST_ADDR_ACK: begin
                if (ack_in == NACK) begin
                  ack_error <= 1'b1;
                  state     <= ST_STOP;
                  sda_lo    <= 1'b1;
                end else if (byte_cnt == '0) begin
                  state  <= ST_STOP;
                  sda_lo <= 1'b1;
                end else if (rw_q) begin
                  state   <= ST_RD_DATA;
                  bit_cnt <= 3'd7;
                  sda_lo  <= 1'b0;
                end else begin
                  state    <= ST_WR_DATA;
                  tx_ready <= 1'b1;
                end
              end
              ST_WR_ACK: begin
                byte_cnt <= byte_left;
                if (ack_in == NACK) begin
                  ack_error <= 1'b1;
                  state     <= ST_STOP;
                  sda_lo    <= 1'b1;
                end else if (byte_left == '0) begin
                  state  <= ST_STOP;
                  sda_lo <= 1'b1;
                end else begin
                  state    <= ST_WR_DATA;
                  tx_ready <= 1'b1;
                end
              end
              ST_RD_DATA: begin
                if (bit_cnt == 3'd0) begin
                  state  <= ST_RD_ACK;
                  // ACK while more bytes follow, NACK (release) on the last one
                  sda_lo <= (byte_cnt != LEN_W'(1));
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                end
              end
              ST_RD_ACK: begin
                byte_cnt <= byte_left;
                if (byte_left == '0) begin
                  state  <= ST_STOP;
                  sda_lo <= 1'b1;
                end else begin
                  state   <= ST_RD_DATA;
                  bit_cnt <= 3'd7;
                  sda_lo  <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule
